// File: rtl/reg_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : shared widths, entry layout and helpers for the write-back arbiter
// Rev 1.0
// ============================================================================
package wb_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int WB_BITS    = 32;

  // Layout of one buffered load at the default word width.
  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_BITS-1:0]    data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// reg_writeback_arbiter_if : ALU/load producer ports and bank write port
// Rev 1.0
// ============================================================================
interface reg_writeback_arbiter_if import wb_pkg::*; #(
  parameter int BITS = 32
) ();

  logic                  ALU_VALID;
  logic [REG_ADDR_W-1:0] ALU_A3;
  logic [BITS-1:0]       ALU_WD;
  logic                  ALU_READY;
  logic                  MEM_VALID;
  logic [REG_ADDR_W-1:0] MEM_A3;
  logic [BITS-1:0]       MEM_WD;
  logic                  MEM_READY;
  logic                  WE3;
  logic [REG_ADDR_W-1:0] A3;
  logic [BITS-1:0]       WD3;
  logic [NUM_REGS-1:0]   PEND_MASK;

  modport master (
    output ALU_VALID, ALU_A3, ALU_WD, MEM_VALID, MEM_A3, MEM_WD,
    input  ALU_READY, MEM_READY, WE3, A3, WD3, PEND_MASK
  );

  modport slave (
    input  ALU_VALID, ALU_A3, ALU_WD, MEM_VALID, MEM_A3, MEM_WD,
    output ALU_READY, MEM_READY, WE3, A3, WD3, PEND_MASK
  );

endinterface
`default_nettype wire

// File: rtl/reg_writeback_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo : circular load buffer with per-entry live bits cleared by address
// Rev 1.0
// ============================================================================
module wb_fifo import wb_pkg::*; #(
  parameter int BITS  = 32,
  parameter int DEPTH = 4
) (
  input  wire logic                             CLK,
  input  wire logic                             RST,
  input  wire logic                             i_push,
  input  wire logic [REG_ADDR_W-1:0]            i_push_addr,
  input  wire logic [BITS-1:0]                  i_push_data,
  input  wire logic                             i_pop,
  input  wire logic                             i_cancel,
  input  wire logic [REG_ADDR_W-1:0]            i_cancel_addr,
  output logic                                  o_full,
  output logic                                  o_empty,
  output logic                                  o_head_live,
  output logic [REG_ADDR_W-1:0]                 o_head_addr,
  output logic [BITS-1:0]                       o_head_data,
  output logic [DEPTH-1:0]                      o_live_vec,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      o_addr_vec
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

  logic [DEPTH-1:0]                 r_live;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][BITS-1:0]       r_data;
  logic [c_ptr_w-1:0]               r_head;
  logic [c_ptr_w-1:0]               r_tail;
  logic [c_cnt_w-1:0]               r_count;
  logic                             w_push_live;

  // A younger ALU write to the same register kills the entry on its way in.
  assign w_push_live = !(i_cancel && (i_cancel_addr == i_push_addr));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_live  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_cancel) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_addr[i] == i_cancel_addr) r_live[i] <= 1'b0;
        end
      end
      // Vacated slots are kept dead so the live vector needs no occupancy mask.
      if (i_pop) begin
        r_live[r_head] <= 1'b0;
        r_head         <= r_head + c_ptr_w'(1);
      end
      if (i_push) begin
        r_live[r_tail] <= w_push_live;
        r_addr[r_tail] <= i_push_addr;
        r_data[r_tail] <= i_push_data;
        r_tail         <= r_tail + c_ptr_w'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full      = (r_count == c_full_cnt);
  assign o_empty     = (r_count == '0);
  assign o_head_live = r_live[r_head];
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  assign o_live_vec  = r_live;
  assign o_addr_vec  = r_addr;

endmodule
`default_nettype wire

// File: rtl/reg_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// reg_writeback_arbiter : merges ALU and load results onto the bank write port
// Rev 1.0
// ============================================================================
module reg_writeback_arbiter import wb_pkg::*; #(
  parameter int BITS         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  reg_writeback_arbiter_if.slave bus
);

  localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

  logic                             w_full;
  logic                             w_empty;
  logic                             w_head_live;
  logic [REG_ADDR_W-1:0]            w_head_addr;
  logic [BITS-1:0]                  w_head_data;
  logic [DEPTH-1:0]                 w_live_vec;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_addr_vec;
  logic                             w_alu_ready;
  logic                             w_alu_acc;
  logic                             w_push;
  logic                             w_pop;
  logic [NUM_REGS-1:0]              w_pend;

  logic [c_starve_w-1:0]            r_starve;
  logic                             r_we3;
  logic [REG_ADDR_W-1:0]            r_a3;
  logic [BITS-1:0]                  r_wd3;

  // Throttling the ALU for one cycle is what guarantees a full FIFO drains.
  assign w_alu_ready = !(w_full && (r_starve == c_starve_max));
  assign w_alu_acc   = bus.ALU_VALID && w_alu_ready;
  assign w_push      = bus.MEM_VALID && !w_full;
  assign w_pop       = !w_alu_acc && !w_empty;

  wb_fifo #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK           (CLK),
    .RST           (RST),
    .i_push        (w_push),
    .i_push_addr   (bus.MEM_A3),
    .i_push_data   (bus.MEM_WD),
    .i_pop         (w_pop),
    .i_cancel      (w_alu_acc),
    .i_cancel_addr (bus.ALU_A3),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_head_live   (w_head_live),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_live_vec    (w_live_vec),
    .o_addr_vec    (w_addr_vec)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_starve <= '0;
    end else if (w_pop) begin
      r_starve <= '0;
    end else if (w_full && w_alu_acc && (r_starve != c_starve_max)) begin
      r_starve <= r_starve + c_starve_w'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_we3 <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else if (w_alu_acc) begin
      r_we3 <= 1'b1;
      r_a3  <= bus.ALU_A3;
      r_wd3 <= bus.ALU_WD;
    end else if (w_pop) begin
      // A cancelled entry still pops, but must not write the bank.
      r_we3 <= w_head_live;
      r_a3  <= w_head_addr;
      r_wd3 <= w_head_data;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live_vec[i]) w_pend = w_pend | addr_onehot(w_addr_vec[i]);
    end
  end

  assign bus.ALU_READY = w_alu_ready;
  assign bus.MEM_READY = !w_full;
  assign bus.WE3       = r_we3;
  assign bus.A3        = r_a3;
  assign bus.WD3       = r_wd3;
  assign bus.PEND_MASK = w_pend;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// tb_reg_writeback_arbiter : directed and random checks against a queue model
// Rev 1.0
// ============================================================================
module tb_reg_writeback_arbiter;
  import wb_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  // Reference model: the FIFO as a queue plus the visible bank-port registers.
  wb_entry_t   mq[$];
  int          m_starve;
  logic        m_we;
  logic [3:0]  m_a3;
  logic [31:0] m_wd;

  reg_writeback_arbiter_if #(.BITS(32)) bus ();

  reg_writeback_arbiter #(
    .BITS         (32),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.ALU_VALID = 1'b0;
    bus.ALU_A3    = '0;
    bus.ALU_WD    = '0;
    bus.MEM_VALID = 1'b0;
    bus.MEM_A3    = '0;
    bus.MEM_WD    = '0;
  endtask

  // Called at a falling edge; reset takes effect without waiting for a clock.
  task automatic do_reset();
    drive_idle();
    RST = 1'b1;
    #1;
    mq.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_a3     = '0;
    m_wd     = '0;
    check("rst_we3",       bus.WE3,       1'b0);
    check("rst_a3",        bus.A3,        4'd0);
    check("rst_wd3",       bus.WD3,       32'd0);
    check("rst_pend_mask", bus.PEND_MASK, 16'd0);
    check("rst_mem_ready", bus.MEM_READY, 1'b1);
    check("rst_alu_ready", bus.ALU_READY, 1'b1);
    @(posedge CLK);
    #1;
    check("rst_we3_held",  bus.WE3,       1'b0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                      input logic mv, input logic [3:0] ma, input logic [31:0] md);
    wb_entry_t   e;
    logic        e_full;
    logic        e_alu_rdy;
    logic        acc;
    logic        push;
    logic        popped;
    logic [15:0] e_pend;
    bus.ALU_VALID = av;
    bus.ALU_A3    = aa;
    bus.ALU_WD    = ad;
    bus.MEM_VALID = mv;
    bus.MEM_A3    = ma;
    bus.MEM_WD    = md;
    #1;
    e_full    = (mq.size() == DEPTH);
    e_alu_rdy = !(e_full && (m_starve == STARVE_LIMIT));
    e_pend    = '0;
    foreach (mq[i]) if (mq[i].live) e_pend = e_pend | (16'(1) << mq[i].addr);
    check("alu_ready", bus.ALU_READY, e_alu_rdy);
    check("mem_ready", bus.MEM_READY, !e_full);
    check("pend_mask", bus.PEND_MASK, e_pend);

    acc    = av && e_alu_rdy;
    push   = mv && !e_full;
    popped = 1'b0;
    if (acc) begin
      m_we = 1'b1;
      m_a3 = aa;
      m_wd = ad;
      foreach (mq[i]) begin
        if (mq[i].addr == aa) begin
          e       = mq[i];
          e.live  = 1'b0;
          mq[i]   = e;
        end
      end
    end else if (mq.size() > 0) begin
      e      = mq.pop_front();
      m_we   = e.live;
      m_a3   = e.addr;
      m_wd   = e.data;
      popped = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (push) begin
      e.live = !(acc && (aa == ma));
      e.addr = ma;
      e.data = md;
      mq.push_back(e);
    end
    if (popped) m_starve = 0;
    else if (e_full && acc && (m_starve < STARVE_LIMIT)) m_starve++;

    @(posedge CLK);
    #1;
    check("we3", bus.WE3, m_we);
    check("a3",  bus.A3,  m_a3);
    check("wd3", bus.WD3, m_wd);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    int n_thr;
    int pa;
    int pm;
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    drive_idle();
    @(negedge CLK);
    do_reset();

    // Single ALU write appears on the port one cycle later.
    step(1'b1, 4'd5, 32'h0001_0000, 1'b0, 4'd0, 32'd0);
    check("alu_first_we3", bus.WE3, 1'b1);
    check("alu_first_a3",  bus.A3,  4'd5);
    check("alu_first_wd3", bus.WD3, 32'h0001_0000);
    idle(1);

    // Four loads with the ALU idle drain in order, two cycles behind each push.
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'(i), 32'(i * 'h11));
      if (i == 2) begin
        check("load1_a3",  bus.A3,  4'd1);
        check("load1_wd3", bus.WD3, 32'h11);
      end
    end
    idle(4);

    // Busy ALU fills the FIFO and is throttled exactly once to drain reg 1.
    n_thr = 0;
    for (int i = 0; i < 14; i++) begin
      if (!bus.ALU_READY) begin
        n_thr++;
        step(1'b1, 4'd10, 32'(i), 1'b1, 4'((i % 4) + 1), 32'('h100 + i));
        check("throttle_we3", bus.WE3, 1'b1);
        check("throttle_a3",  bus.A3,  4'd1);
      end else begin
        step(1'b1, 4'd10, 32'(i), 1'b1, 4'((i % 4) + 1), 32'('h100 + i));
      end
    end
    check("throttle_count", 64'(n_thr), 64'd1);
    idle(6);

    // Buffered load to reg 7 cancelled by a younger ALU write.
    step(1'b1, 4'd3, 32'h33, 1'b1, 4'd7, 32'h77);
    step(1'b1, 4'd7, 32'hAB, 1'b0, 4'd0, 32'd0);
    check("cancel_wd3",   bus.WD3,          32'hAB);
    check("cancel_pend7", bus.PEND_MASK[7], 1'b0);
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    check("cancel_dead_we3", bus.WE3, 1'b0);
    idle(2);

    // Same-cycle push and ALU write to reg 9: the enqueued entry is born dead.
    step(1'b1, 4'd9, 32'h99AA, 1'b1, 4'd9, 32'h1234);
    check("same_cycle_wd3",   bus.WD3,          32'h99AA);
    check("same_cycle_pend9", bus.PEND_MASK[9], 1'b0);
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    check("same_cycle_dead_we3", bus.WE3, 1'b0);
    idle(2);

    // Reset with three loads buffered discards them.
    for (int i = 1; i <= 3; i++) step(1'b1, 4'd12, 32'(i), 1'b1, 4'(i), 32'('hC0 + i));
    check("pre_reset_pend", bus.PEND_MASK, 16'h000E);
    do_reset();
    idle(5);

    // Random traffic at increasing ALU pressure, with one reset mid-stream.
    for (int ph = 0; ph < 3; ph++) begin
      pa = (ph == 0) ? 30 : (ph == 1) ? 70 : 95;
      pm = (ph == 0) ? 50 : (ph == 1) ? 80 : 90;
      for (int n = 0; n < 150; n++) begin
        if (ph == 1 && n == 75) do_reset();
        step(1'b1 && ($urandom_range(99) < pa), 4'($urandom_range(ph == 2 ? 3 : 15)), $urandom,
             1'b1 && ($urandom_range(99) < pm), 4'($urandom_range(ph == 2 ? 3 : 15)), $urandom);
      end
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
